// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// Shift register plus one holding register streams words with no gap bits.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Encoding is {hold_full, active}
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SHIFT      = 2'b01,
        SHIFT_FULL = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             active;
    logic             hold_full;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] shifted;

    assign active    = state_q[0];
    assign hold_full = state_q[1];
    assign last      = (cnt_q == LAST);
    assign accept    = load_valid && !hold_full;

    assign load_ready = !hold_full;
    assign dout_valid = active;
    assign word_done  = active && last;
    assign busy       = active || hold_full;
    assign dout       = active ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                               : IDLE_BIT;

    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d  = load_data;
                        state_d = SHIFT_FULL;
                    end
                end else if (accept) begin
                    // Reload straight into the shifter: no gap bit
                    shreg_d = load_data;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_FULL: begin
                if (!last) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    shreg_d = hold_q;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
